flag_unit: RTL and testbench

Producer side of the branch flag interface. Computes and holds the processor's Z/V/N condition flags from the EX-stage ALU result, with per-opcode update masks. Presents the registered flag vector `F` to branch resolution in ID. Detects the one-cycle hazard where a conditional branch in ID needs flags that the instruction in EX has not yet written, and raises a stall for that cycle.

---
 rtl/flag_unit.sv | 90 +++++++++
 tb/tb_flag_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/flag_unit.sv
// Z/V/N condition-flag register fed by the EX-stage ALU result, with per-opcode write masks,
// plus the one-cycle branch-flag hazard detector for the conditional branch in ID.
module flag_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_stall,
   input  logic        ex_flush,
   input  logic [3:0]  ex_opcode,
   input  logic [15:0] ex_result,
   input  logic        ex_ovfl,
   input  logic        id_valid,
   input  logic [3:0]  id_opcode,
   input  logic [2:0]  id_cond,
   output logic [2:0]  F,
   output logic        flag_hazard
);

   logic       cls_zvn_s;
   logic       cls_z_s;
   logic       ex_writer_s;
   logic       upd_s;
   logic [2:0] f_nxt_s;
   logic [2:0] f_r;
   logic       id_br_s;
   logic       ex_wr_any_s;
   logic       ex_wr_v_s;

   // Decode the EX opcode into its flag-write class.
   always_comb begin
      cls_zvn_s = 1'b0;
      cls_z_s   = 1'b0;
      case (ex_opcode)
         4'b0000, 4'b0001: cls_zvn_s = 1'b1;
         4'b0010, 4'b0100,
         4'b0101, 4'b0110: cls_z_s   = 1'b1;
         default: begin
            cls_zvn_s = 1'b0;
            cls_z_s   = 1'b0;
         end
      endcase
   end

   assign ex_writer_s = cls_zvn_s | cls_z_s;
   assign upd_s       = ex_valid & ~ex_stall & ~ex_flush & ex_writer_s;

   // Next flag value: Z for any writer, V and N only for the add/sub class; others hold.
   always_comb begin
      f_nxt_s = f_r;
      if (upd_s) begin
         f_nxt_s[2] = (ex_result == 16'h0000);
         if (cls_zvn_s) begin
            f_nxt_s[1] = ex_ovfl;
            f_nxt_s[0] = ex_result[15];
         end else begin
            f_nxt_s[1] = f_r[1];
            f_nxt_s[0] = f_r[0];
         end
      end else begin
         f_nxt_s = f_r;
      end
   end

   // Flag register; reset discards any write presented in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         f_r <= 3'b000;
      end else begin
         f_r <= f_nxt_s;
      end
   end

   assign F = f_r;

   // Stall is ignored here: a stalled EX already holds ID, and the writer is still pending.
   assign id_br_s     = id_valid & (id_opcode[3:1] == 3'b110) & (id_cond != 3'b111);
   assign ex_wr_any_s = ex_valid & ~ex_flush & ex_writer_s;
   assign ex_wr_v_s   = ex_valid & ~ex_flush & cls_zvn_s;

   // Condition 110 reads V alone, so only a V writer in EX blocks it.
   always_comb begin
      flag_hazard = 1'b0;
      if (id_cond == 3'b110) begin
         flag_hazard = id_br_s & ex_wr_v_s;
      end else begin
         flag_hazard = id_br_s & ex_wr_any_s;
      end
   end

endmodule

// File: tb/tb_flag_unit.sv
// Scoreboard bench for flag_unit: a reference model pushes expected hazard/flag values as
// stimulus is driven; they are popped and compared as the DUT presents them.
module tb_flag_unit;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_XOR = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_LW  = 4'b1000;
   localparam logic [3:0] OP_B   = 4'b1100;
   localparam logic [3:0] OP_BR  = 4'b1101;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_stall, ex_flush, ex_ovfl;
   logic [3:0]  ex_opcode;
   logic [15:0] ex_result;
   logic        id_valid;
   logic [3:0]  id_opcode;
   logic [2:0]  id_cond;
   logic [2:0]  F;
   logic        flag_hazard;

   typedef struct {
      logic [2:0] f;
      logic       hz;
   } exp_t;

   exp_t       sb_q[$];
   logic [2:0] model_f = 3'b000;
   int         checks = 0;
   int         errors = 0;

   flag_unit dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_flush(ex_flush),
      .ex_opcode(ex_opcode), .ex_result(ex_result), .ex_ovfl(ex_ovfl),
      .id_valid(id_valid), .id_opcode(id_opcode), .id_cond(id_cond),
      .F(F), .flag_hazard(flag_hazard)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One pipeline cycle: drive, predict, check hazard mid-cycle, check F after the edge.
   task automatic step(input string tag,
                       input logic r, input logic v, input logic st, input logic fl,
                       input logic [3:0] op, input logic [15:0] res, input logic ov,
                       input logic idv, input logic [3:0] idop, input logic [2:0] idc);
      exp_t e;
      logic zvn, zc, id_br;
      @(negedge clk);
      rst = r; ex_valid = v; ex_stall = st; ex_flush = fl;
      ex_opcode = op; ex_result = res; ex_ovfl = ov;
      id_valid = idv; id_opcode = idop; id_cond = idc;
      zvn   = (op == OP_ADD) || (op == OP_SUB);
      zc    = (op == 4'd2) || (op == 4'd4) || (op == 4'd5) || (op == 4'd6);
      id_br = idv && (idop == OP_B || idop == OP_BR) && (idc != 3'b111);
      e.hz  = id_br && v && !fl && ((idc == 3'b110) ? zvn : (zvn || zc));
      e.f   = model_f;
      if (r) begin
         e.f = 3'b000;
      end else if (v && !st && !fl && (zvn || zc)) begin
         e.f[2] = (res == 16'h0000);
         if (zvn) begin
            e.f[1] = ov;
            e.f[0] = res[15];
         end
      end
      model_f = e.f;
      sb_q.push_back(e);
      #1;
      check_eq({tag, "_hz"}, {15'd0, flag_hazard}, {15'd0, sb_q[0].hz});
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check_eq({tag, "_sb_empty"}, 16'd1, 16'd0);
      end else begin
         e = sb_q.pop_front();
         check_eq({tag, "_F"}, {13'd0, F}, {13'd0, e.f});
      end
   endtask

   initial begin
      rst = 1'b1; ex_valid = 1'b0; ex_stall = 1'b0; ex_flush = 1'b0;
      ex_opcode = 4'd0; ex_result = 16'd0; ex_ovfl = 1'b0;
      id_valid = 1'b0; id_opcode = 4'd0; id_cond = 3'd0;

      // Reset with a live ADD in EX, and a branch in ID to see the hazard during reset
      step("rst0", 1'b1, 1'b1, 1'b0, 1'b0, OP_ADD, 16'h8000, 1'b1, 1'b1, OP_B, 3'b000);
      step("rst1", 1'b1, 1'b1, 1'b0, 1'b0, OP_ADD, 16'h8000, 1'b1, 1'b0, OP_B, 3'b000);
      step("add_first", 1'b0, 1'b1, 1'b0, 1'b0, OP_ADD, 16'h8000, 1'b1, 1'b0, 4'd0, 3'd0);
      // Masking
      step("xor_z", 1'b0, 1'b1, 1'b0, 1'b0, OP_XOR, 16'h0000, 1'b0, 1'b0, 4'd0, 3'd0);
      step("sll_nz", 1'b0, 1'b1, 1'b0, 1'b0, OP_SLL, 16'h0004, 1'b0, 1'b0, 4'd0, 3'd0);
      step("lw_none", 1'b0, 1'b1, 1'b0, 1'b0, OP_LW, 16'h0000, 1'b1, 1'b0, 4'd0, 3'd0);
      // Flush / stall / release
      step("sub_flush", 1'b0, 1'b1, 1'b0, 1'b1, OP_SUB, 16'h0000, 1'b0, 1'b0, 4'd0, 3'd0);
      step("sub_both", 1'b0, 1'b1, 1'b1, 1'b1, OP_SUB, 16'h0000, 1'b0, 1'b0, 4'd0, 3'd0);
      step("sub_stall", 1'b0, 1'b1, 1'b1, 1'b0, OP_SUB, 16'h0000, 1'b0, 1'b1, OP_B, 3'b010);
      step("sub_rel", 1'b0, 1'b1, 1'b0, 1'b0, OP_SUB, 16'h0000, 1'b0, 1'b0, 4'd0, 3'd0);
      // Hazard cases
      step("hz_add", 1'b0, 1'b1, 1'b0, 1'b0, OP_ADD, 16'h0001, 1'b0, 1'b1, OP_B, 3'b000);
      step("hz_xor_c6", 1'b0, 1'b1, 1'b0, 1'b0, OP_XOR, 16'h0001, 1'b0, 1'b1, OP_B, 3'b110);
      step("hz_add_c6", 1'b0, 1'b1, 1'b0, 1'b0, OP_ADD, 16'h0001, 1'b0, 1'b1, OP_BR, 3'b110);
      step("hz_c7", 1'b0, 1'b1, 1'b0, 1'b0, OP_ADD, 16'h0001, 1'b0, 1'b1, OP_B, 3'b111);
      step("hz_lw", 1'b0, 1'b1, 1'b0, 1'b0, OP_LW, 16'h0000, 1'b0, 1'b1, OP_BR, 3'b011);
      step("hz_flush", 1'b0, 1'b1, 1'b0, 1'b1, OP_ADD, 16'h0000, 1'b0, 1'b1, OP_B, 3'b001);
      step("hz_noid", 1'b0, 1'b1, 1'b0, 1'b0, OP_ADD, 16'h0000, 1'b0, 1'b0, OP_B, 3'b001);
      // Hazard resolution from F=000, plus reset discarding a pending write
      step("res_rst", 1'b1, 1'b1, 1'b0, 1'b0, OP_SUB, 16'h8000, 1'b1, 1'b0, 4'd0, 3'd0);
      step("res_t", 1'b0, 1'b1, 1'b0, 1'b0, OP_SUB, 16'h0000, 1'b0, 1'b1, OP_B, 3'b001);
      step("res_t1", 1'b0, 1'b0, 1'b0, 1'b0, OP_LW, 16'h0000, 1'b0, 1'b1, OP_B, 3'b001);
      // Sign / overflow corners
      step("add_7fff", 1'b0, 1'b1, 1'b0, 1'b0, OP_ADD, 16'h7FFF, 1'b1, 1'b0, 4'd0, 3'd0);
      step("sub_ffff", 1'b0, 1'b1, 1'b0, 1'b0, OP_SUB, 16'hFFFF, 1'b0, 1'b0, 4'd0, 3'd0);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         logic [15:0] res;
         res = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
         step("rand", ($urandom_range(0, 31) == 0), 1'($urandom), ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 4) == 0), 4'($urandom), res, 1'($urandom),
              1'($urandom), ($urandom_range(0, 1) == 0) ? OP_B : 4'($urandom), 3'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
